// File: rtl/char_motion_if.sv
// Signal bundle between the game-state/keyboard logic and the character motion block.
// The master drives keys, crashes and the freeze/respawn handshake; the slave returns the sprite state.
interface char_motion_if;
  logic        startOfFrame;
  logic        leftPress;
  logic        rightPress;
  logic        leftCrash;
  logic        rightCrash;
  logic        freeze;
  logic        respawn;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [3:0]  speed;
  logic        facingLeft;
  logic        frozen;

  modport master (
    output startOfFrame, leftPress, rightPress, leftCrash, rightCrash, freeze, respawn,
    input  topLeftX, topLeftY, speed, facingLeft, frozen
  );

  modport slave (
    input  startOfFrame, leftPress, rightPress, leftCrash, rightCrash, freeze, respawn,
    output topLeftX, topLeftY, speed, facingLeft, frozen
  );
endinterface

// File: rtl/char_motion.sv
// Per-frame X motion of the player character on the bottom walkway: speed ramp, edge clamp,
// crash blocking and freeze/respawn. Define CHAR_WRAP_EN to replace the edge clamp with wrap-around.
//
// state  | meaning
// IDLE   | no accepted move request; speed 0
// MOVE_L | moving left, speed ramping
// MOVE_R | moving right, speed ramping
// FROZEN | hit; motion stopped until respawn
module char_motion #(
  parameter int SCREEN_W     = 640,
  parameter int CHAR_W       = 32,
  parameter int CHAR_HIGHT   = 32,
  parameter int GROUND_Y     = 479,
  parameter int INITIAL_X    = 320,
  parameter int MAX_SPEED    = 4,
  parameter int ACCEL_FRAMES = 8
) (
  input logic          clk,
  input logic          resetN,
  char_motion_if.slave bus
);

  localparam logic [11:0] X_MAX     = 12'(SCREEN_W - CHAR_W);
  localparam logic [10:0] X_INIT    = 11'(INITIAL_X);
  localparam logic [3:0]  SPEED_MAX = 4'(MAX_SPEED);
  localparam logic [7:0]  ACCEL_TC  = 8'(ACCEL_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R, FROZEN} state_t;

  state_t      state_q;
  logic [10:0] x_q;
  logic [3:0]  speed_q;
  logic [7:0]  accel_q;
  logic        facing_q;
  logic        frozen_q;

  logic        req_l;
  logic        req_r;
  logic        crash;
  state_t      req_state;
  logic [3:0]  speed_d;
  logic [7:0]  accel_d;
  logic [10:0] x_d;
  logic [11:0] x_ext;
  logic [11:0] spd_ext;
  logic [11:0] sum;

  always_comb begin
    req_l     = bus.leftPress & ~bus.rightPress;
    req_r     = bus.rightPress & ~bus.leftPress;
    req_state = req_l ? MOVE_L : MOVE_R;
    crash     = (req_l & bus.leftCrash) | (req_r & bus.rightCrash);

    // A new direction (or start from IDLE) restarts the ramp at speed 1.
    speed_d = speed_q;
    accel_d = accel_q + 8'd1;
    if (state_q != req_state) begin
      speed_d = 4'd1;
      accel_d = 8'd0;
    end else if (accel_q == ACCEL_TC) begin
      accel_d = 8'd0;
      if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
    end

    x_ext   = {1'b0, x_q};
    spd_ext = {8'd0, speed_d};
    sum     = x_ext + spd_ext;
    x_d     = x_q;
    if (req_l) begin
`ifdef CHAR_WRAP_EN
      x_d = (x_ext < spd_ext) ? X_MAX[10:0] : x_q - 11'(speed_d);
`else
      x_d = (x_ext <= spd_ext) ? 11'd0 : x_q - 11'(speed_d);
`endif
    end else begin
`ifdef CHAR_WRAP_EN
      x_d = (sum > X_MAX) ? 11'd0 : sum[10:0];
`else
      x_d = (sum >= X_MAX) ? X_MAX[10:0] : sum[10:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      x_q      <= X_INIT;
      speed_q  <= 4'd0;
      accel_q  <= 8'd0;
      facing_q <= 1'b0;
      frozen_q <= 1'b0;
    end else if (bus.respawn) begin
      state_q  <= IDLE;
      x_q      <= X_INIT;
      speed_q  <= 4'd0;
      accel_q  <= 8'd0;
      frozen_q <= 1'b0;
    end else if (bus.freeze && state_q != FROZEN) begin
      state_q  <= FROZEN;
      frozen_q <= 1'b1;
      speed_q  <= 4'd0;
      accel_q  <= 8'd0;
    end else if (bus.startOfFrame && state_q != FROZEN) begin
      if (!(req_l || req_r)) begin
        state_q <= IDLE;
        speed_q <= 4'd0;
        accel_q <= 8'd0;
      end else begin
        facing_q <= req_l;
        if (crash) begin
          state_q <= IDLE;
          speed_q <= 4'd0;
          accel_q <= 8'd0;
        end else begin
          state_q <= req_state;
          speed_q <= speed_d;
          accel_q <= accel_d;
          x_q     <= x_d;
        end
      end
    end
  end

  assign bus.topLeftX   = x_q;
  assign bus.topLeftY   = 11'(GROUND_Y - CHAR_HIGHT + 1);
  assign bus.speed      = speed_q;
  assign bus.facingLeft = facing_q;
  assign bus.frozen     = frozen_q;

endmodule

// File: tb/tb_char_motion.sv
// Scoreboard bench for char_motion: a behavioural model pushes the expected sprite state for
// every driven cycle; the entry is popped and compared one clock later.
module tb_char_motion;
  localparam int X_MAX = 640 - 32;
  localparam int INIT  = 320;
  localparam int MAXS  = 4;
  localparam int AF    = 8;

  typedef struct {
    int x;
    int spd;
    int face;
    int frz;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;
  char_motion_if bus();

  char_motion dut (.clk(clk), .resetN(resetN), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb_q[$];

  // model state: mst 0=idle 1=left 2=right 3=frozen
  int mx = INIT, mspd = 0, macc = 0, mst = 0, mface = 0, mfrz = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model(input int sof, input int l, input int r, input int lc, input int rc,
                       input int frz, input int rsp);
    int req;
    if (rsp != 0) begin
      mx = INIT; mspd = 0; macc = 0; mst = 0; mfrz = 0;
    end else if (frz != 0 && mst != 3) begin
      mst = 3; mfrz = 1; mspd = 0;
    end else if (sof != 0 && mst != 3) begin
      req = (l != 0 && r == 0) ? 1 : (r != 0 && l == 0) ? 2 : 0;
      if (req == 0) begin
        mst = 0; mspd = 0; macc = 0;
      end else begin
        mface = (req == 1) ? 1 : 0;
        if ((req == 1 && lc != 0) || (req == 2 && rc != 0)) begin
          mst = 0; mspd = 0; macc = 0;
        end else begin
          if (req != mst) begin
            mst = req; mspd = 1; macc = 0;
          end else if (macc == AF - 1) begin
            macc = 0;
            mspd = (mspd + 1 > MAXS) ? MAXS : mspd + 1;
          end else begin
            macc = macc + 1;
          end
`ifdef CHAR_WRAP_EN
          if (req == 1) mx = (mx - mspd < 0) ? X_MAX : mx - mspd;
          else          mx = (mx + mspd > X_MAX) ? 0 : mx + mspd;
`else
          if (req == 1) mx = (mx - mspd <= 0) ? 0 : mx - mspd;
          else          mx = (mx + mspd >= X_MAX) ? X_MAX : mx + mspd;
`endif
        end
      end
    end
  endtask

  task automatic cycle(input int sof, input int l, input int r, input int lc, input int rc,
                       input int frz, input int rsp);
    exp_t e;
    @(negedge clk);
    bus.startOfFrame = sof[0];
    bus.leftPress    = l[0];
    bus.rightPress   = r[0];
    bus.leftCrash    = lc[0];
    bus.rightCrash   = rc[0];
    bus.freeze       = frz[0];
    bus.respawn      = rsp[0];
    model(sof, l, r, lc, rc, frz, rsp);
    e.x = mx; e.spd = mspd; e.face = mface; e.frz = mfrz;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("x", int'(bus.topLeftX), e.x);
    check("y", int'(bus.topLeftY), 448);
    check("speed", int'(bus.speed), e.spd);
    check("facing", int'(bus.facingLeft), e.face);
    check("frozen", int'(bus.frozen), e.frz);
  endtask

  task automatic frame(input int l, input int r, input int lc, input int rc);
    cycle(1, l, r, lc, rc, 0, 0);
    cycle(0, l, r, lc, rc, 0, 0);
    cycle(0, l, r, lc, rc, 0, 0);
  endtask

  initial begin
    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.leftPress = 1'b0; bus.rightPress = 1'b0;
    bus.leftCrash = 1'b0; bus.rightCrash = 1'b0; bus.freeze = 1'b0; bus.respawn = 1'b0;
    #23;
    check("rst_x", int'(bus.topLeftX), 320);
    check("rst_speed", int'(bus.speed), 0);
    check("rst_frozen", int'(bus.frozen), 0);
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < 3; i++) frame(0, 0, 0, 0);
    check("idle_x", int'(bus.topLeftX), 320);
    check("idle_face", int'(bus.facingLeft), 0);

    for (int i = 0; i < 20; i++) frame(0, 1, 0, 0);
    check("ramp_x", int'(bus.topLeftX), 356);
    check("ramp_speed", int'(bus.speed), 3);

    frame(0, 1, 0, 0);
    frame(0, 1, 0, 1);
    check("crash_x", int'(bus.topLeftX), 359);
    check("crash_speed", int'(bus.speed), 0);
    frame(0, 1, 1, 0);
    check("uncrash_x", int'(bus.topLeftX), 360);
    check("uncrash_speed", int'(bus.speed), 1);

    frame(1, 1, 0, 0);
    check("both_speed", int'(bus.speed), 0);
    check("both_x", int'(bus.topLeftX), 360);
    for (int i = 0; i < 3; i++) frame(1, 0, 0, 0);
    check("left_face", int'(bus.facingLeft), 1);
    frame(0, 1, 0, 0);
    check("rev_x", int'(bus.topLeftX), 358);
    check("rev_speed", int'(bus.speed), 1);
    check("rev_face", int'(bus.facingLeft), 0);

    for (int i = 0; i < 120; i++) frame(1, 0, 0, 0);
`ifndef CHAR_WRAP_EN
    check("clamp_x", int'(bus.topLeftX), 0);
`endif
    for (int i = 0; i < 10; i++) frame(0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) frame(0, 1, 0, 0);
    check("frz_flag", int'(bus.frozen), 1);
    check("frz_speed", int'(bus.speed), 0);
    cycle(0, 0, 1, 0, 0, 1, 1);
    check("rsp_x", int'(bus.topLeftX), 320);
    check("rsp_frozen", int'(bus.frozen), 0);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 3 == 0) ? 1 : 0, int'($urandom % 2), int'($urandom % 2),
            ($urandom % 4 == 0) ? 1 : 0, ($urandom % 4 == 0) ? 1 : 0,
            ($urandom % 50 == 0) ? 1 : 0, ($urandom % 40 == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
